// File: rtl/pep_batch_scheduler.sv
// pep_batch_scheduler
// Collects PBS slot ids into an arrival-ordered pending queue and issues them
// in batches of up to BATCH_PBS_NB. A batch goes out when the queue can fill
// it, on flush, or once a partial batch has waited BATCH_TIMEOUT cycles.
// Only one batch is in flight at a time; batch_done retires it.
module pep_batch_scheduler #(
  parameter int TOTAL_PBS_NB  = 32,
  parameter int BATCH_PBS_NB  = 12,
  parameter int BATCH_TIMEOUT = 64,
  localparam int PID_W = $clog2(TOTAL_PBS_NB),
  localparam int BNB_W = $clog2(BATCH_PBS_NB + 1)
) (
  input  logic             clk,
  input  logic             a_rst_n,
  input  logic [PID_W-1:0] in_pid,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic             flush,
  output logic [BNB_W-1:0] cmd_pbs_nb,
  output logic             cmd_vld,
  input  logic             cmd_rdy,
  output logic [PID_W-1:0] bpid,
  output logic             bpid_last,
  output logic             bpid_vld,
  input  logic             bpid_rdy,
  input  logic             batch_done,
  output logic [PID_W:0]   pending_cnt,
  output logic             busy,
  output logic             err_done
);

  localparam int TO_W = $clog2(BATCH_TIMEOUT + 1);
  localparam logic [PID_W:0]   CNT_MAX   = (PID_W+1)'(TOTAL_PBS_NB);
  localparam logic [PID_W:0]   CNT_BATCH = (PID_W+1)'(BATCH_PBS_NB);
  localparam logic [PID_W-1:0] PTR_LAST  = PID_W'(TOTAL_PBS_NB - 1);
  localparam logic [TO_W-1:0]  TO_LAST   = TO_W'(BATCH_TIMEOUT - 1);

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CMD, S_SEND, S_RUN} state_t;

  state_t           state_reg, state_next;
  logic [PID_W-1:0] mem [TOTAL_PBS_NB];
  logic [PID_W-1:0] wr_ptr_reg, rd_ptr_reg;
  logic [PID_W:0]   cnt_reg;
  logic             rdy_en_reg;
  logic [TO_W-1:0]  to_cnt_reg;
  logic [BNB_W-1:0] nb_reg;
  logic [BNB_W-1:0] sent_reg;
  logic             err_reg;

  logic             push, pop;
  logic             has_pend, full_batch, timeout_hit, is_last;
  logic             enter_cmd, enter_wait;
  logic [BNB_W-1:0] batch_nb;

  // Handshake qualifiers and queue status decodes
  always_comb begin
    has_pend    = (cnt_reg != '0);
    full_batch  = (cnt_reg >= CNT_BATCH);
    timeout_hit = (to_cnt_reg == TO_LAST);
    is_last     = (sent_reg == (nb_reg - BNB_W'(1)));
    in_rdy      = rdy_en_reg & (cnt_reg < CNT_MAX);
    push        = in_vld & in_rdy;
    pop         = (state_reg == S_SEND) & bpid_rdy;
    batch_nb    = full_batch ? BNB_W'(BATCH_PBS_NB) : BNB_W'(cnt_reg);
    enter_cmd   = (state_next == S_CMD) && (state_reg != S_CMD);
    enter_wait  = (state_next == S_WAIT) && (state_reg != S_WAIT);
  end

  // Next-state logic for the batch controller
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (has_pend && (flush || full_batch)) state_next = S_CMD;
        else if (has_pend)                     state_next = S_WAIT;
      end
      S_WAIT: begin
        if (full_batch || flush || timeout_hit) state_next = S_CMD;
      end
      S_CMD: begin
        if (cmd_rdy) state_next = S_SEND;
      end
      S_SEND: begin
        if (bpid_rdy && is_last) state_next = S_RUN;
      end
      S_RUN: begin
        if (batch_done) begin
          if (has_pend && (flush || full_batch)) state_next = S_CMD;
          else if (has_pend)                     state_next = S_WAIT;
          else                                   state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output decode; bpid is forced to zero outside SEND so it reads 0 after reset
  always_comb begin
    cmd_vld     = (state_reg == S_CMD);
    cmd_pbs_nb  = nb_reg;
    bpid_vld    = (state_reg == S_SEND);
    bpid        = (state_reg == S_SEND) ? mem[rd_ptr_reg] : '0;
    bpid_last   = (state_reg == S_SEND) & is_last;
    busy        = (state_reg == S_CMD) || (state_reg == S_SEND) || (state_reg == S_RUN);
    pending_cnt = cnt_reg;
    err_done    = err_reg;
  end

  // State register
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  // Pending queue storage; no reset so it maps onto RAM
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= in_pid;
  end

  // Queue pointers and occupancy; in_rdy is held low until the first clock after reset
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      rdy_en_reg <= 1'b0;
    end else begin
      rdy_en_reg <= 1'b1;
      if (push) wr_ptr_reg <= (wr_ptr_reg == PTR_LAST) ? '0 : wr_ptr_reg + PID_W'(1);
      if (pop)  rd_ptr_reg <= (rd_ptr_reg == PTR_LAST) ? '0 : rd_ptr_reg + PID_W'(1);
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + (PID_W+1)'(1);
        2'b01:   cnt_reg <= cnt_reg - (PID_W+1)'(1);
        default: cnt_reg <= cnt_reg;
      endcase
    end
  end

  // Partial-batch timeout: restarts on every WAIT entry, counts while waiting
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n)                  to_cnt_reg <= '0;
    else if (enter_wait)           to_cnt_reg <= '0;
    else if (state_reg == S_WAIT)  to_cnt_reg <= to_cnt_reg + TO_W'(1);
  end

  // Batch size is frozen on CMD entry so later pushes cannot grow the batch
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      nb_reg   <= '0;
      sent_reg <= '0;
    end else begin
      if (enter_cmd) nb_reg <= batch_nb;
      if (state_reg == S_CMD) sent_reg <= '0;
      else if (pop)           sent_reg <= sent_reg + BNB_W'(1);
    end
  end

  // Flag a batch_done that arrives with no batch in flight
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) err_reg <= 1'b0;
    else          err_reg <= batch_done && (state_reg != S_RUN);
  end

endmodule

// File: doc/pep_batch_scheduler.md
PEP_BATCH_SCHEDULER -- requirements
Module: pep_batch_scheduler

Interface
REQ-001 SHALL have parameter TOTAL_PBS_NB, default 32, meaning PBS slots stored in HPU and depth of the pending queue.
REQ-002 SHALL have parameter BATCH_PBS_NB, default 12, meaning maximum PBS per batch (<= TOTAL_PBS_NB).
REQ-003 SHALL have parameter BATCH_TIMEOUT, default 64, meaning the number of cycles a partial batch waits before issue (>= 1).
REQ-004 SHALL derive PID_W = $clog2(TOTAL_PBS_NB) and BNB_W = $clog2(BATCH_PBS_NB+1).
REQ-005 SHALL have one clock and an asynchronous active-low reset: clk  in  1  clock; a_rst_n  in  1  async reset, active low.
REQ-006 in_pid  in  PID_W  slot id of a PBS ready for processing.
REQ-007 in_vld  in  1 / in_rdy  out  1  pending-PBS push handshake.
REQ-008 flush  in  1  level; issue any pending PBS without waiting for the timeout.
REQ-009 cmd_pbs_nb  out  BNB_W / cmd_vld  out  1 / cmd_rdy  in  1  batch command carrying the PBS count.
REQ-010 bpid  out  PID_W / bpid_last  out  1 / bpid_vld  out  1 / bpid_rdy  in  1  PID stream of the issued batch.
REQ-011 batch_done  in  1  single-cycle pulse; the in-flight batch has completed.
REQ-012 pending_cnt  out  PID_W+1  queue occupancy; busy  out  1  batch in flight; err_done  out  1  one-cycle pulse on an unexpected batch_done.

Function
REQ-013 SHALL hold pending PIDs in a FIFO of depth TOTAL_PBS_NB, in arrival order.
REQ-014 in_rdy SHALL be 1 iff pending_cnt < TOTAL_PBS_NB; a push and a pop in the same cycle SHALL leave pending_cnt unchanged.
REQ-015 SHALL implement the states IDLE, WAIT, CMD, SEND, RUN; only one batch SHALL be in flight (BATCH_NB = 1).
REQ-016 IDLE -> WAIT when pending_cnt > 0; WAIT SHALL clear the timeout counter on entry and increment it each cycle while in WAIT.
REQ-017 WAIT -> CMD when pending_cnt >= BATCH_PBS_NB, or flush = 1, or the timeout counter = BATCH_TIMEOUT-1.
REQ-018 IDLE SHALL go directly to CMD when flush = 1 and pending_cnt > 0, or when pending_cnt >= BATCH_PBS_NB.
REQ-019 On entry to CMD, SHALL latch cmd_pbs_nb = min(pending_cnt, BATCH_PBS_NB) and hold it stable until cmd_rdy.
REQ-020 cmd_vld SHALL be 1 only in CMD; CMD -> SEND on cmd_vld & cmd_rdy.
REQ-021 In SEND, bpid SHALL present the FIFO head with bpid_vld = 1; each bpid_vld & bpid_rdy SHALL pop one PID.
REQ-022 bpid_last SHALL be 1 on the cmd_pbs_nb-th PID; SEND -> RUN on its handshake.
REQ-023 bpid and bpid_last SHALL be stable while bpid_vld = 1 and bpid_rdy = 0.
REQ-024 busy SHALL be 1 in CMD, SEND and RUN.
REQ-025 RUN -> WAIT on batch_done if pending_cnt > 0 (with the flush/full rules of REQ-018 applied in that cycle); otherwise RUN -> IDLE.
REQ-026 batch_done outside RUN SHALL be ignored and SHALL pulse err_done for one cycle.
REQ-027 Pushes SHALL be accepted in every state; PIDs pushed during CMD/SEND SHALL NOT join the latched batch beyond cmd_pbs_nb.
REQ-028 The PID value SHALL NOT be checked for duplicates.

Reset
REQ-029 On a_rst_n = 0, SHALL asynchronously enter IDLE, empty the FIFO and clear the timeout counter; outputs SHALL read: in_rdy 0 while in reset and 1 after release, cmd_vld 0, cmd_pbs_nb 0, bpid_vld 0, bpid_last 0, bpid 0, pending_cnt 0, busy 0, err_done 0.
REQ-030 Reset mid-batch SHALL discard the batch and all pending PIDs; no cmd or bpid handshake SHALL complete after reset assertion.

Verification
REQ-031 Push PIDs 0..11 back-to-back, cmd_rdy = bpid_rdy = 1 -> cmd_pbs_nb = 12, bpid 0..11 in order, bpid_last on 11, pending_cnt = 0, busy until batch_done.
REQ-032 Push PIDs 3 and 7 only, no flush -> cmd_vld rises exactly BATCH_TIMEOUT cycles after WAIT entry, cmd_pbs_nb = 2, bpid_last on 7.
REQ-033 Push 32 PIDs while cmd_rdy = 0 -> in_rdy = 0 at pending_cnt = 32; after cmd/bpid handshakes, 12 issued, pending_cnt = 20, in_rdy = 1.
REQ-034 Push 5 PIDs, assert flush -> batch of 5 issued in the next CMD; bpid_rdy toggling 1/0 -> bpid held stable while stalled.
REQ-035 batch_done pulse in IDLE -> err_done one-cycle pulse, state unchanged; a_rst_n low during SEND -> all outputs at reset values, pending_cnt 0.
